// File: rtl/riscv_lsu_pkg.sv
// Shared types and access-size helpers for the riscv load/store unit.
package riscv_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Undefined encodings fall through to a full-word access.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << lane;
            F3_H, F3_HU: return lane[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_repl(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            F3_B, F3_BU: return {4{data[7:0]}};
            F3_H, F3_HU: return {2{data[15:0]}};
            default:     return data;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] word,
                                             input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'h0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'h0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return lane[0];
            default:     return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_be.sv
// Single-port word memory with per-byte write enables, synchronous write and
// combinational read of the addressed word.
module riscv_dmem_be #(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    // NOTE: the storage array carries no reset; clearing it would cost a write
    // port per word and software never relies on power-up contents.
    logic [31:0] mem_q [2**IDX_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/riscv_lsu_mem.sv
// Load/store unit with wait-state latency and an integrated byte-enabled data memory.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module riscv_lsu_mem
    import riscv_lsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int WAIT_ST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] load_data,
    output logic              resp_valid,
    output logic              stall,
    output logic              misalign_err,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int         IDX_W     = ADDR_W - 2;
    localparam logic [3:0] WAIT_INIT = (WAIT_ST > 0) ? 4'(WAIT_ST - 1) : 4'd0;

    lsu_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              store_q, store_d;
    logic              mis_q, mis_d;

    logic              req;
    logic              mem_we;
    logic [3:0]        be;
    logic [31:0]       repl, merged, mem_rdata;

    assign req = MemRead | MemWrite;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its next-state signal.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            f3_q    <= '0;
            data_q  <= '0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            data_q  <= data_d;
            store_q <= store_d;
            mis_q   <= mis_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        data_d  = data_q;
        store_d = store_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr_in;
                    f3_d    = Funct3;
                    data_d  = store_data;
                    store_d = MemWrite;
`ifdef MISALIGN_TRAP_EN
                    mis_d   = is_misaligned(Funct3, addr_in[1:0]);
`else
                    mis_d   = 1'b0;
`endif
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_ST == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign be   = byte_en(f3_q, addr_q[1:0]);
    assign repl = store_repl(f3_q, data_q);

    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = repl[8*i +: 8];
        end
    end

    // Reset gates every output, including the write strobe, so an access
    // interrupted in RESP never reaches the array.
    always_comb begin
        load_data    = '0;
        resp_valid   = 1'b0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        wr           = 1'b0;
        rd           = 1'b0;
        addr         = '0;
        wr_data      = '0;
        rd_data      = '0;
        mem_we       = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: stall = req;
                WAIT: stall = 1'b1;
                RESP: begin
                    resp_valid   = 1'b1;
                    misalign_err = mis_q;
                    if (!mis_q) begin
                        addr = addr_q;
                        if (store_q) begin
                            mem_we  = 1'b1;
                            wr      = 1'b1;
                            wr_data = merged;
                        end else begin
                            rd        = 1'b1;
                            rd_data   = mem_rdata;
                            load_data = load_ext(f3_q, mem_rdata, addr_q[1:0]);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    riscv_dmem_be #(
        .IDX_W (IDX_W)
    ) u_dmem (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (be),
        .idx_i   (addr_q[ADDR_W-1:2]),
        .wdata_i (repl),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_riscv_lsu_mem.sv
// Self-checking bench: two LSU instances (WAIT_ST=2 and WAIT_ST=3) share stimulus
// and are compared against a byte-array reference model.
module tb_riscv_lsu_mem;

    logic        clk = 1'b0;
    logic        reset, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [8:0]  addr_in;
    logic [31:0] store_data;

    logic [31:0] ld_2, wd_2, rdd_2, ld_3, wd_3, rdd_3;
    logic [8:0]  ta_2, ta_3;
    logic        rv_2, st_2, me_2, w_2, r_2;
    logic        rv_3, st_3, me_3, w_3, r_3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [512];

    always #5 clk = ~clk;

    riscv_lsu_mem #(.DATA_W(32), .ADDR_W(9), .WAIT_ST(2)) u_dut2 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .addr_in(addr_in), .store_data(store_data),
        .load_data(ld_2), .resp_valid(rv_2), .stall(st_2), .misalign_err(me_2),
        .wr(w_2), .rd(r_2), .addr(ta_2), .wr_data(wd_2), .rd_data(rdd_2)
    );

    riscv_lsu_mem #(.DATA_W(32), .ADDR_W(9), .WAIT_ST(3)) u_dut3 (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .addr_in(addr_in), .store_data(store_data),
        .load_data(ld_3), .resp_valid(rv_3), .stall(st_3), .misalign_err(me_3),
        .wr(w_3), .rd(r_3), .addr(ta_3), .wr_data(wd_3), .rd_data(rdd_3)
    );

    typedef struct {
        logic [7:0]  stall_m;
        logic [7:0]  resp_m;
        logic        leak;
        logic [31:0] ld;
        logic [31:0] wd;
        logic [31:0] rdd;
        logic [8:0]  ta;
        logic        w;
        logic        r;
        logic        me;
    } obs_t;

    typedef struct {
        bit          rq;
        bit          wq;
        logic [2:0]  f3;
        logic [8:0]  a;
        logic [31:0] d;
        logic [31:0] exp_ld;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a flat byte array addressed exactly like the byte address.
    function automatic logic [31:0] m_word(input logic [8:0] a);
        int b;
        b = int'(a) & ~3;
        return {mem_m[b+3], mem_m[b+2], mem_m[b+1], mem_m[b]};
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [8:0] a);
        int h;
        logic [7:0]  bv;
        logic [15:0] hv;
        h  = int'(a) & ~1;
        bv = mem_m[int'(a)];
        hv = {mem_m[h+1], mem_m[h]};
        case (f3)
            3'b000:  return {{24{bv[7]}}, bv};
            3'b100:  return {24'h0, bv};
            3'b001:  return {{16{hv[15]}}, hv};
            3'b101:  return {16'h0, hv};
            default: return m_word(a);
        endcase
    endfunction

    function automatic void m_store(input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
        int h, b;
        h = int'(a) & ~1;
        b = int'(a) & ~3;
        case (f3)
            3'b000: mem_m[int'(a)] = d[7:0];
            3'b001: begin
                mem_m[h]   = d[7:0];
                mem_m[h+1] = d[15:8];
            end
            default: begin
                mem_m[b]   = d[7:0];
                mem_m[b+1] = d[15:8];
                mem_m[b+2] = d[23:16];
                mem_m[b+3] = d[31:24];
            end
        endcase
    endfunction

    task automatic observe(inout obs_t o, input int c, input logic st, input logic rv,
                           input logic me, input logic w, input logic r, input logic [8:0] ta,
                           input logic [31:0] ld, input logic [31:0] wd, input logic [31:0] rdd);
        if (st) o.stall_m[c] = 1'b1;
        if (rv) begin
            o.resp_m[c] = 1'b1;
            o.ld  = ld;
            o.wd  = wd;
            o.rdd = rdd;
            o.ta  = ta;
            o.w   = w;
            o.r   = r;
            o.me  = me;
        end else if (w || r || me || ta != 0 || ld != 0 || wd != 0 || rdd != 0) begin
            o.leak = 1'b1;
        end
    endtask

    task automatic verify(input string tag, input obs_t o, input int ws, input bit rst_mid,
                          input bit is_st, input bit is_ld, input logic [31:0] exp_ld,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd, input logic [8:0] a);
        if (rst_mid) begin
            check({tag, " resp_after_reset"}, 32'(o.resp_m), 32'd0);
            check({tag, " trace_after_reset"}, 32'(o.leak), 32'd0);
        end else begin
            check({tag, " stall_cycles"}, 32'(o.stall_m), 32'((1 << (ws + 1)) - 1));
            check({tag, " resp_cycle"}, 32'(o.resp_m), 32'(1 << (ws + 1)));
            check({tag, " idle_outputs"}, 32'(o.leak), 32'd0);
            check({tag, " load_data"}, o.ld, exp_ld);
            check({tag, " misalign_err"}, 32'(o.me), 32'd0);
            check({tag, " trace_wr"}, 32'(o.w), 32'(is_st));
            check({tag, " trace_rd"}, 32'(o.r), 32'(is_ld));
            check({tag, " trace_addr"}, 32'(o.ta), 32'(a));
            if (is_st) check({tag, " wr_data"}, o.wd, exp_wd);
            if (is_ld) check({tag, " rd_data"}, o.rdd, exp_rd);
        end
    endtask

    // One request pulse, then an 8-cycle observation window covering both latencies.
    task automatic do_access(input bit rq, input bit wq, input logic [2:0] f3, input logic [8:0] a,
                             input logic [31:0] d, input bit rst_mid, output logic [31:0] ld_out);
        obs_t o2, o3;
        bit is_st, is_ld;
        logic [31:0] exp_rd, exp_ld, exp_wd;
        is_st  = wq;
        is_ld  = rq && !wq;
        exp_rd = m_word(a);
        exp_ld = is_ld ? m_load(f3, a) : 32'h0;
        exp_wd = 32'h0;
        if (is_st && !rst_mid) begin
            m_store(f3, a, d);
            exp_wd = m_word(a);
        end
        o2 = '{default: '0};
        o3 = '{default: '0};
        @(posedge clk);
        #1;
        MemRead    = rq;
        MemWrite   = wq;
        Funct3     = f3;
        addr_in    = a;
        store_data = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            observe(o2, c, st_2, rv_2, me_2, w_2, r_2, ta_2, ld_2, wd_2, rdd_2);
            observe(o3, c, st_3, rv_3, me_3, w_3, r_3, ta_3, ld_3, wd_3, rdd_3);
            @(posedge clk);
            #1;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            reset    = rst_mid && (c == 1);
        end
        verify("ws2", o2, 2, rst_mid, is_st, is_ld, exp_ld, exp_wd, exp_rd, a);
        verify("ws3", o3, 3, rst_mid, is_st, is_ld, exp_ld, exp_wd, exp_rd, a);
        ld_out = o2.ld;
    endtask

    initial begin
        vec_t        vecs [18];
        logic [31:0] ld;
        logic [2:0]  ld_f3 [8];
        logic [2:0]  st_f3 [5];

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};

        vecs[0]  = '{0, 1, 3'b010, 9'h010, 32'h0102_0304, 32'h0};
        vecs[1]  = '{1, 0, 3'b010, 9'h010, 32'h0,         32'h0102_0304};
        vecs[2]  = '{0, 1, 3'b010, 9'h020, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1, 0, 3'b010, 9'h020, 32'h0,         32'h1122_3344};
        vecs[4]  = '{0, 1, 3'b000, 9'h023, 32'h0000_0080, 32'h0};
        vecs[5]  = '{1, 0, 3'b000, 9'h023, 32'h0,         32'hFFFF_FF80};
        vecs[6]  = '{1, 0, 3'b100, 9'h023, 32'h0,         32'h0000_0080};
        vecs[7]  = '{1, 0, 3'b010, 9'h020, 32'h0,         32'h8022_3344};
        vecs[8]  = '{0, 1, 3'b010, 9'h030, 32'h1234_5678, 32'h0};
        vecs[9]  = '{0, 1, 3'b001, 9'h032, 32'h0000_BEEF, 32'h0};
        vecs[10] = '{1, 0, 3'b001, 9'h032, 32'h0,         32'hFFFF_BEEF};
        vecs[11] = '{1, 0, 3'b101, 9'h032, 32'h0,         32'h0000_BEEF};
        vecs[12] = '{1, 0, 3'b010, 9'h030, 32'h0,         32'hBEEF_5678};
        vecs[13] = '{0, 1, 3'b010, 9'h1FC, 32'hCAFE_F00D, 32'h0};
        vecs[14] = '{1, 0, 3'b010, 9'h1FC, 32'h0,         32'hCAFE_F00D};
        vecs[15] = '{1, 0, 3'b010, 9'h022, 32'h0,         32'h8022_3344};
        vecs[16] = '{1, 1, 3'b010, 9'h020, 32'h0000_0055, 32'h0};
        vecs[17] = '{1, 0, 3'b011, 9'h020, 32'h0,         32'h0000_0055};

        for (int i = 0; i < 512; i++) mem_m[i] = 8'h00;

        reset      = 1'b1;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Funct3     = 3'b000;
        addr_in    = '0;
        store_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset stall", 32'({st_2, st_3}), 32'd0);
        check("reset resp_valid", 32'({rv_2, rv_3}), 32'd0);
        check("reset load_data", ld_2 | ld_3, 32'd0);
        check("reset trace", 32'({w_2, r_2, w_3, r_3, me_2, me_3}), 32'd0);
        check("reset trace_data", wd_2 | rdd_2 | wd_3 | rdd_3 | 32'(ta_2) | 32'(ta_3), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Give every word a known value so the model and the arrays agree.
        for (int i = 0; i < 128; i++) do_access(0, 1, 3'b010, 9'(i * 4), 32'h0, 0, ld);

        do_access(vecs[0].rq, vecs[0].wq, vecs[0].f3, vecs[0].a, vecs[0].d, 0, ld);
        // Store aborted by reset while the access is still waiting.
        do_access(0, 1, 3'b010, 9'h010, 32'hDEAD_BEEF, 1, ld);

        for (int i = 1; i < 18; i++) begin
            do_access(vecs[i].rq, vecs[i].wq, vecs[i].f3, vecs[i].a, vecs[i].d, 0, ld);
            check($sformatf("vec%0d load_data", i), ld, vecs[i].exp_ld);
        end

        for (int i = 0; i < 300; i++) begin
            int          op;
            logic [2:0]  f3;
            logic [8:0]  a;
            logic [31:0] d;
            op = int'($urandom_range(0, 2));
            a  = 9'($urandom_range(0, 511));
            d  = $urandom;
            if (op == 0) begin
                f3 = ld_f3[$urandom_range(0, 7)];
                do_access(1, 0, f3, a, d, 0, ld);
            end else begin
                f3 = st_f3[$urandom_range(0, 4)];
                do_access(op == 2, 1, f3, a, d, 0, ld);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
